// File: rtl/pool_window_gen_if.sv
// Pixel-stream in / pooling-window out bundle for pool_window_gen.
// The sof signal exists only when POOL_WIN_SOF_EN is defined.
interface pool_window_gen_if #(
    parameter int DATA_WIDTH = 8,
    parameter int WIN_SIZE   = 3
);
    // Handshake: no back-pressure. din (and sof) are consumed on every rising
    // edge where din_vld is high; win_vld is a one-cycle strobe qualifying win
    // and eof, and win holds its value until the next accepted pixel.
    logic                                           din_vld;
    logic signed [DATA_WIDTH-1:0]                   din;
`ifdef POOL_WIN_SOF_EN
    logic                                           sof;
`endif
    logic                                           win_vld;
    logic [WIN_SIZE-1:0][WIN_SIZE-1:0][DATA_WIDTH-1:0] win;
    logic                                           eof;

`ifdef POOL_WIN_SOF_EN
    modport master (output din_vld, din, sof, input win_vld, win, eof);
    modport slave  (input din_vld, din, sof, output win_vld, win, eof);
`else
    modport master (output din_vld, din, input win_vld, win, eof);
    modport slave  (input din_vld, din, output win_vld, win, eof);
`endif
endinterface

// File: rtl/pool_window_gen.sv
// Sliding WIN_SIZE x WIN_SIZE window generator with stride for a pooling core.
// Optional feature: define POOL_WIN_SOF_EN to add the sof frame-restart input.
module pool_window_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int WIN_SIZE   = 3,
    parameter int STRIDE     = 3,
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32
) (
    input logic               clk,
    input logic               reset_n,
    pool_window_gen_if.slave  bus
);
    localparam int CW       = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW       = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int PW       = (STRIDE     > 1) ? $clog2(STRIDE)     : 1;
    localparam int LAST_ROW = (WIN_SIZE - 1) + ((IMG_HEIGHT - WIN_SIZE) / STRIDE) * STRIDE;
    localparam int LAST_COL = (WIN_SIZE - 1) + ((IMG_WIDTH  - WIN_SIZE) / STRIDE) * STRIDE;

    typedef logic [DATA_WIDTH-1:0] pix_t;

    logic [CW-1:0] col, cur_col;
    logic [RW-1:0] row, cur_row;
    logic [PW-1:0] col_ph, cur_col_ph, next_col_ph;
    logic [PW-1:0] row_ph, cur_row_ph, next_row_ph;
    logic          col_last, row_last, qualify, at_last;
    logic          win_vld_q, eof_q;
    logic [WIN_SIZE-1:0][WIN_SIZE-1:0][DATA_WIDTH-1:0] win_q;

    // lb[0] is the oldest stored line, lb[WIN_SIZE-2] the line just above din.
    pix_t lb [WIN_SIZE-1][IMG_WIDTH];
    pix_t new_col [WIN_SIZE];

    // Position of the pixel being accepted; sof overrides it to (0,0).
    always_comb begin
        cur_col    = col;
        cur_row    = row;
        cur_col_ph = col_ph;
        cur_row_ph = row_ph;
`ifdef POOL_WIN_SOF_EN
        if (bus.sof) begin
            cur_col    = '0;
            cur_row    = '0;
            cur_col_ph = '0;
            cur_row_ph = '0;
        end
`endif
    end

    // Stride phases stay 0 until the counter reaches WIN_SIZE-1, then cycle mod STRIDE.
    always_comb begin
        col_last    = (cur_col == CW'(IMG_WIDTH - 1));
        row_last    = (cur_row == RW'(IMG_HEIGHT - 1));
        next_col_ph = '0;
        next_row_ph = '0;
        if (cur_col >= CW'(WIN_SIZE - 1))
            next_col_ph = (cur_col_ph == PW'(STRIDE - 1)) ? '0 : cur_col_ph + PW'(1);
        if (cur_row >= RW'(WIN_SIZE - 1))
            next_row_ph = (cur_row_ph == PW'(STRIDE - 1)) ? '0 : cur_row_ph + PW'(1);
        qualify = (cur_row >= RW'(WIN_SIZE - 1)) && (cur_col >= CW'(WIN_SIZE - 1)) &&
                  (cur_row_ph == '0) && (cur_col_ph == '0);
        at_last = (cur_row == RW'(LAST_ROW)) && (cur_col == CW'(LAST_COL));
    end

    always_comb begin
        for (int k = 0; k < WIN_SIZE - 1; k++) new_col[k] = lb[k][cur_col];
        new_col[WIN_SIZE-1] = bus.din;
    end

    // Line storage is never cleared: row qualification hides stale lines.
    always_ff @(posedge clk) begin
        if (bus.din_vld) begin
            for (int k = 0; k < WIN_SIZE - 2; k++) lb[k][cur_col] <= lb[k+1][cur_col];
            lb[WIN_SIZE-2][cur_col] <= bus.din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col       <= '0;
            row       <= '0;
            col_ph    <= '0;
            row_ph    <= '0;
            win_vld_q <= 1'b0;
            eof_q     <= 1'b0;
            win_q     <= '0;
        end else begin
            win_vld_q <= 1'b0;
            eof_q     <= 1'b0;
            if (bus.din_vld) begin
                win_vld_q <= qualify;
                eof_q     <= qualify && at_last;
                for (int r = 0; r < WIN_SIZE; r++) begin
                    for (int c = 0; c < WIN_SIZE - 1; c++) win_q[r][c] <= win_q[r][c+1];
                    win_q[r][WIN_SIZE-1] <= new_col[r];
                end
                if (col_last) begin
                    col    <= '0;
                    col_ph <= '0;
                    if (row_last) begin
                        row    <= '0;
                        row_ph <= '0;
                    end else begin
                        row    <= cur_row + RW'(1);
                        row_ph <= next_row_ph;
                    end
                end else begin
                    col    <= cur_col + CW'(1);
                    col_ph <= next_col_ph;
                end
            end
        end
    end

    assign bus.win_vld = win_vld_q;
    assign bus.eof     = eof_q;
    assign bus.win     = win_q;
endmodule

// File: tb/tb_pool_window_gen.sv
// Bench for pool_window_gen: stride-3 and stride-1 instances on a 6x6 image,
// driven with the same pixel stream and checked against a reference model.
`timescale 1ns/1ps
module tb_pool_window_gen;
  localparam int DW = 8;
  localparam int WS = 3;
  localparam int IW = 6;
  localparam int IH = 6;
  localparam int WW = WS * WS * DW;
  localparam int EW = 32 + 1 + WW;

  typedef struct {
    int pat;
    int gap;
    int frames;
    int n3;
    int n1;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pool_window_gen_if #(.DATA_WIDTH(DW), .WIN_SIZE(WS)) bus3 ();
  pool_window_gen_if #(.DATA_WIDTH(DW), .WIN_SIZE(WS)) bus1 ();

  pool_window_gen #(.DATA_WIDTH(DW), .WIN_SIZE(WS), .STRIDE(3), .IMG_WIDTH(IW), .IMG_HEIGHT(IH))
    dut3 (.clk(clk), .reset_n(reset_n), .bus(bus3.slave));
  pool_window_gen #(.DATA_WIDTH(DW), .WIN_SIZE(WS), .STRIDE(1), .IMG_WIDTH(IW), .IMG_HEIGHT(IH))
    dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1.slave));

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  logic [EW-1:0] exp_q3[$];
  logic [EW-1:0] exp_q1[$];
  int stb3, stb1;
  logic [WW-1:0] first3, last3, second1;
  logic last_eof3;
  logic [DW-1:0] img [IH][IW];
  int mrow, mcol;
  vec_t vecs[5];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [WW-1:0] got, input logic [WW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, want);
    end
  endtask

  function automatic logic [DW-1:0] pix(input logic [WW-1:0] w, input int r, input int c);
    return w[(r*WS+c)*DW +: DW];
  endfunction

  function automatic bit qual(input int r, input int c, input int s);
    return (r >= WS-1) && (c >= WS-1) && ((r-(WS-1)) % s == 0) && ((c-(WS-1)) % s == 0);
  endfunction

  function automatic int lastpos(input int s, input int n);
    int l;
    l = 0;
    for (int q = 0; q < n; q++) if (q >= WS-1 && (q-(WS-1)) % s == 0) l = q;
    return l;
  endfunction

  // Reference model: record the pixel, push the expected window for each stride.
  task automatic model_accept(input logic [DW-1:0] v, input logic s);
    logic [WW-1:0] w;
    logic e;
    int strides[2];
    strides[0] = 3;
    strides[1] = 1;
    if (s) begin
      mrow = 0;
      mcol = 0;
    end
    img[mrow][mcol] = v;
    foreach (strides[i]) begin
      if (qual(mrow, mcol, strides[i])) begin
        for (int r = 0; r < WS; r++)
          for (int c = 0; c < WS; c++)
            w[(r*WS+c)*DW +: DW] = img[mrow-(WS-1)+r][mcol-(WS-1)+c];
        e = (mrow == lastpos(strides[i], IH)) && (mcol == lastpos(strides[i], IW));
        if (strides[i] == 3) exp_q3.push_back({32'(cyc_cnt + 1), e, w});
        else                 exp_q1.push_back({32'(cyc_cnt + 1), e, w});
      end
    end
    if (mcol == IW-1) begin
      mcol = 0;
      mrow = (mrow == IH-1) ? 0 : mrow + 1;
    end else begin
      mcol = mcol + 1;
    end
  endtask

  // ---------------- driver ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_pix(input logic [DW-1:0] v, input logic s);
    bus3.din_vld = 1'b1;
    bus1.din_vld = 1'b1;
    bus3.din = v;
    bus1.din = v;
`ifdef POOL_WIN_SOF_EN
    bus3.sof = s;
    bus1.sof = s;
`endif
    model_accept(v, s);
    @(posedge clk);
    #1;
    bus3.din_vld = 1'b0;
    bus1.din_vld = 1'b0;
`ifdef POOL_WIN_SOF_EN
    bus3.sof = 1'b0;
    bus1.sof = 1'b0;
`endif
  endtask

  task automatic send_frame(input int pat, input int gap, input logic sof_first);
    logic [DW-1:0] v;
    for (int r = 0; r < IH; r++) begin
      for (int c = 0; c < IW; c++) begin
        if (pat == 0)      v = DW'(IW*r + c);
        else if (pat == 1) v = (((r + c) % 2) != 0) ? 8'h7f : 8'h80;
        else               v = DW'($urandom_range(0, 255));
        drive_pix(v, sof_first && r == 0 && c == 0);
        if (gap == 1)      idle(1);
        else if (gap == 2) idle($urandom_range(0, 2));
      end
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic mon(input int d, input logic v, input logic [WW-1:0] w, input logic e);
    logic [EW-1:0] x;
    bit have;
    x = '0;
    have = (d == 3) ? (exp_q3.size() > 0) : (exp_q1.size() > 0);
    if (have) x = (d == 3) ? exp_q3[0] : exp_q1[0];
    if (v) begin
      checks++;
      if (!have) begin
        errors++;
        $display("FAIL spurious_win dut%0d cyc %0d got win_vld=1 want 0", d, cyc_cnt);
      end else begin
        if (d == 3) void'(exp_q3.pop_front());
        else        void'(exp_q1.pop_front());
        if ({32'(cyc_cnt), e, w} !== x) begin
          errors++;
          $display("FAIL win dut%0d got cyc=%0d eof=%0b win=%0h want cyc=%0d eof=%0b win=%0h",
                   d, cyc_cnt, e, w, x[EW-1 -: 32], x[WW], x[WW-1:0]);
        end
      end
      if (d == 3) begin
        if (stb3 == 0) first3 = w;
        last3 = w;
        last_eof3 = e;
        stb3++;
      end else begin
        if (stb1 == 1) second1 = w;
        stb1++;
      end
    end else if (have && x[EW-1 -: 32] <= 32'(cyc_cnt)) begin
      checks++;
      errors++;
      $display("FAIL missing_win dut%0d cyc %0d got win_vld=0 want 1 (due cyc %0d)",
               d, cyc_cnt, x[EW-1 -: 32]);
      if (d == 3) void'(exp_q3.pop_front());
      else        void'(exp_q1.pop_front());
    end
  endtask

  always @(negedge clk) begin
    mon(3, bus3.win_vld, bus3.win, bus3.eof);
    mon(1, bus1.win_vld, bus1.win, bus1.eof);
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_vld3"}, WW'(bus3.win_vld), '0);
    chk({tag, "_eof3"}, WW'(bus3.eof), '0);
    chk({tag, "_win3"}, bus3.win, '0);
    chk({tag, "_vld1"}, WW'(bus1.win_vld), '0);
    chk({tag, "_win1"}, bus1.win, '0);
  endtask

  task automatic check_ref_frame(input string tag);
    chk({tag, "_first_w00"}, WW'(pix(first3, 0, 0)), WW'(0));
    chk({tag, "_first_w02"}, WW'(pix(first3, 0, 2)), WW'(2));
    chk({tag, "_first_w20"}, WW'(pix(first3, 2, 0)), WW'(12));
    chk({tag, "_first_w22"}, WW'(pix(first3, 2, 2)), WW'(14));
    chk({tag, "_last_w22"},  WW'(pix(last3, 2, 2)),  WW'(35));
    chk({tag, "_last_eof"},  WW'(last_eof3), WW'(1));
    chk({tag, "_s1_second_w00"}, WW'(pix(second1, 0, 0)), WW'(1));
    chk({tag, "_s1_second_w22"}, WW'(pix(second1, 2, 2)), WW'(15));
  endtask

  task automatic check_counts(input string tag, input int n3, input int n1);
    chk({tag, "_count3"}, WW'(stb3), WW'(n3));
    chk({tag, "_count1"}, WW'(stb1), WW'(n1));
    chk({tag, "_q3_empty"}, WW'(exp_q3.size()), '0);
    chk({tag, "_q1_empty"}, WW'(exp_q1.size()), '0);
  endtask

  // ---------------- test ----------------
  initial begin
    vecs[0] = '{pat: 0, gap: 0, frames: 1, n3: 4, n1: 16};
    vecs[1] = '{pat: 0, gap: 1, frames: 1, n3: 4, n1: 16};
    vecs[2] = '{pat: 1, gap: 0, frames: 1, n3: 4, n1: 16};
    vecs[3] = '{pat: 2, gap: 2, frames: 2, n3: 4, n1: 16};
    vecs[4] = '{pat: 0, gap: 0, frames: 3, n3: 4, n1: 16};

    bus3.din_vld = 1'b0;
    bus1.din_vld = 1'b0;
    bus3.din = '0;
    bus1.din = '0;
`ifdef POOL_WIN_SOF_EN
    bus3.sof = 1'b0;
    bus1.sof = 1'b0;
`endif
    mrow = 0;
    mcol = 0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset_n = 1'b1;
    idle(2);

    for (int i = 0; i < 5; i++) begin
      stb3 = 0;
      stb1 = 0;
      for (int f = 0; f < vecs[i].frames; f++) send_frame(vecs[i].pat, vecs[i].gap, 1'b0);
      idle(3);
      check_counts($sformatf("vec%0d", i), vecs[i].n3 * vecs[i].frames, vecs[i].n1 * vecs[i].frames);
      if (vecs[i].pat == 0) check_ref_frame($sformatf("vec%0d", i));
      if (vecs[i].pat == 1) begin
        chk($sformatf("vec%0d_min_w00", i), WW'(pix(first3, 0, 0)), WW'(8'h80));
        chk($sformatf("vec%0d_max_w01", i), WW'(pix(first3, 0, 1)), WW'(8'h7f));
      end
    end

    // Reset pulsed mid-frame after pixel 20, then a clean frame.
    for (int p = 0; p <= 20; p++) drive_pix(DW'(p), 1'b0);
    reset_n = 1'b0;
    exp_q3.delete();
    exp_q1.delete();
    mrow = 0;
    mcol = 0;
    #1;
    check_reset_outputs("midreset");
    idle(2);
    reset_n = 1'b1;
    idle(1);
    stb3 = 0;
    stb1 = 0;
    send_frame(0, 0, 1'b0);
    idle(3);
    check_counts("after_reset", 4, 16);
    check_ref_frame("after_reset");

`ifdef POOL_WIN_SOF_EN
    // Frame abandoned after 10 pixels by sof on the next pixel.
    stb3 = 0;
    stb1 = 0;
    for (int p = 0; p < 10; p++) drive_pix(DW'($urandom_range(0, 255)), 1'b0);
    send_frame(0, 0, 1'b1);
    idle(3);
    check_counts("sof", 4, 16);
    check_ref_frame("sof");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
